sample_stream_fifo: RTL and testbench

//   Parametrised ready/valid stream buffer for simulator-interface test designs.

---
 rtl/sample_stream_fifo_if.sv | 50 +++++
 rtl/sample_stream_fifo.sv | 114 +++++++++++
 tb/tb_sample_stream_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_stream_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_stream_fifo_if
// Brief    : Ready/valid stream, flush and status bundle for sample_stream_fifo
// Revision : 1.0
// ============================================================================
interface sample_stream_fifo_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
);
    logic                           flush;
    logic                           stream_in_valid;
    logic                           stream_in_ready;
    logic [DATA_WIDTH-1:0]          stream_in_data;
    logic                           stream_out_valid;
    logic                           stream_out_ready;
    logic [DATA_WIDTH-1:0]          stream_out_data;
    logic [$clog2(DEPTH+1)-1:0]     level;
    logic                           almost_full;
    logic [COUNT_WIDTH-1:0]         xfer_count;

    // The FIFO itself is the slave; the source/sink environment is the master.
    modport slave (
        input  flush,
        input  stream_in_valid,
        input  stream_in_data,
        input  stream_out_ready,
        output stream_in_ready,
        output stream_out_valid,
        output stream_out_data,
        output level,
        output almost_full,
        output xfer_count
    );

    modport master (
        output flush,
        output stream_in_valid,
        output stream_in_data,
        output stream_out_ready,
        input  stream_in_ready,
        input  stream_out_valid,
        input  stream_out_data,
        input  level,
        input  almost_full,
        input  xfer_count
    );
endinterface
`default_nettype wire

// File: rtl/sample_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_stream_fifo
// Brief    : Parametrised ready/valid FIFO with flush, occupancy and a
//            wrapping output-transfer counter.
// Revision : 1.0
// ============================================================================
module sample_stream_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int AF_THRESH   = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sample_stream_fifo_if.slave   s_bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_AF_LVL   = c_LVL_W'(AF_THRESH);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_LVL_W-1:0]     r_level;
    logic [COUNT_WIDTH-1:0] r_xfer_count;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_push;
    logic                   w_pop;
    logic [c_PTR_W-1:0]     w_wr_ptr_inc;
    logic [c_PTR_W-1:0]     w_rd_ptr_inc;
    logic [c_PTR_W-1:0]     w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]     w_rd_ptr_nxt;
    logic [c_LVL_W-1:0]     w_level_nxt;
    logic [COUNT_WIDTH-1:0] w_xfer_count_nxt;

    // Handshake qualifiers depend on registered level and flush only, so the
    // sink's ready never reaches the source's ready combinationally.
    assign w_in_ready  = reset_n & (r_level != c_FULL_LVL) & ~s_bus.flush;
    assign w_out_valid = reset_n & (r_level != '0) & ~s_bus.flush;

    assign w_push = s_bus.stream_in_valid  & w_in_ready;
    assign w_pop  = s_bus.stream_out_ready & w_out_valid;

    assign w_wr_ptr_inc = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_ONE;
    assign w_rd_ptr_inc = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_ONE;

    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_level_nxt      = r_level;
        w_xfer_count_nxt = r_xfer_count;

        if (w_pop) begin
            w_xfer_count_nxt = r_xfer_count + COUNT_WIDTH'(1);
        end

        if (s_bus.flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_level_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = w_wr_ptr_inc;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = w_rd_ptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + c_LVL_ONE;
                2'b01:   w_level_nxt = r_level - c_LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_xfer_count <= '0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_level      <= w_level_nxt;
            r_xfer_count <= w_xfer_count_nxt;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_bus.stream_in_data;
        end
    end

    assign s_bus.stream_in_ready  = w_in_ready;
    assign s_bus.stream_out_valid = w_out_valid;
    assign s_bus.stream_out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign s_bus.level            = r_level;
    assign s_bus.almost_full      = reset_n & (r_level >= c_AF_LVL);
    assign s_bus.xfer_count       = r_xfer_count;

endmodule
`default_nettype wire

// File: tb/tb_sample_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_stream_fifo
// Brief    : Directed self-checking bench for sample_stream_fifo
// Revision : 1.0
// ============================================================================
module tb_sample_stream_fifo;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    sample_stream_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .COUNT_WIDTH(16)) bus_a ();
    sample_stream_fifo_if #(.DATA_WIDTH(8), .DEPTH(4), .COUNT_WIDTH(2))  bus_b ();

    sample_stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .AF_THRESH  (3),
        .COUNT_WIDTH(16)
    ) u_dut_a (
        .clk    (clk),
        .reset_n(reset_n),
        .s_bus  (bus_a.slave)
    );

    sample_stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .AF_THRESH  (3),
        .COUNT_WIDTH(2)
    ) u_dut_b (
        .clk    (clk),
        .reset_n(reset_n),
        .s_bus  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        bus_a.flush = 1'b0; bus_a.stream_in_valid = 1'b0; bus_a.stream_in_data = 8'h00; bus_a.stream_out_ready = 1'b0;
        bus_b.flush = 1'b0; bus_b.stream_in_valid = 1'b0; bus_b.stream_in_data = 8'h00; bus_b.stream_out_ready = 1'b0;

        // Reset held for three clocks
        repeat (3) tick();
        chk("rst_ready", 32'(bus_a.stream_in_ready), 32'd0);
        chk("rst_valid", 32'(bus_a.stream_out_valid), 32'd0);
        chk("rst_level", 32'(bus_a.level), 32'd0);
        chk("rst_xfer", 32'(bus_a.xfer_count), 32'd0);
        chk("rst_data", 32'(bus_a.stream_out_data), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus_a.stream_in_ready), 32'd1);

        // Fill with sink stalled
        bus_a.stream_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_a.stream_in_data = 8'(8'h11 * (i + 1));
            #1;
            chk("fill_ready", 32'(bus_a.stream_in_ready), 32'd1);
            tick();
            chk("fill_level", 32'(bus_a.level), 32'(i + 1));
            chk("fill_af", 32'(bus_a.almost_full), 32'((i + 1) >= 3));
        end
        chk("full_ready", 32'(bus_a.stream_in_ready), 32'd0);
        bus_a.stream_in_data = 8'h55;
        tick();
        chk("full_level", 32'(bus_a.level), 32'd4);
        bus_a.stream_in_valid = 1'b0;

        // Drain on consecutive cycles
        bus_a.stream_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(bus_a.stream_out_valid), 32'd1);
            chk("drain_data", 32'(bus_a.stream_out_data), 32'(8'h11 * (i + 1)));
            tick();
        end
        chk("drain_xfer", 32'(bus_a.xfer_count), 32'd4);
        chk("drain_valid_end", 32'(bus_a.stream_out_valid), 32'd0);
        chk("drain_data_end", 32'(bus_a.stream_out_data), 32'd0);
        chk("drain_level_end", 32'(bus_a.level), 32'd0);

        // Continuous streaming across several pointer wraps
        bus_a.stream_in_valid = 1'b1;
        bus_a.stream_in_data  = 8'd0;
        #1;
        chk("strm_valid0", 32'(bus_a.stream_out_valid), 32'd0);
        tick();
        for (int k = 1; k <= 14; k++) begin
            bus_a.stream_in_data = 8'(k);
            #1;
            chk("strm_valid", 32'(bus_a.stream_out_valid), 32'd1);
            chk("strm_data", 32'(bus_a.stream_out_data), 32'(k - 1));
            chk("strm_level", 32'(bus_a.level), 32'd1);
            tick();
        end
        bus_a.stream_in_valid = 1'b0;
        #1;
        chk("strm_last", 32'(bus_a.stream_out_data), 32'd14);
        tick();
        chk("strm_level_end", 32'(bus_a.level), 32'd0);
        chk("strm_xfer", 32'(bus_a.xfer_count), 32'd19);

        // Flush with source still offering data
        bus_a.stream_out_ready = 1'b0;
        bus_a.stream_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.stream_in_data = 8'(8'hA1 + i);
            tick();
        end
        chk("fl_level_pre", 32'(bus_a.level), 32'd3);
        bus_a.flush            = 1'b1;
        bus_a.stream_in_data   = 8'hAA;
        bus_a.stream_out_ready = 1'b1;
        #1;
        chk("fl_ready", 32'(bus_a.stream_in_ready), 32'd0);
        chk("fl_valid", 32'(bus_a.stream_out_valid), 32'd0);
        tick();
        bus_a.flush            = 1'b0;
        bus_a.stream_in_valid  = 1'b0;
        bus_a.stream_out_ready = 1'b0;
        #1;
        chk("fl_level", 32'(bus_a.level), 32'd0);
        chk("fl_valid_post", 32'(bus_a.stream_out_valid), 32'd0);
        chk("fl_xfer", 32'(bus_a.xfer_count), 32'd19);
        bus_a.stream_in_valid = 1'b1;
        bus_a.stream_in_data  = 8'h5C;
        tick();
        bus_a.stream_in_valid  = 1'b0;
        bus_a.stream_out_ready = 1'b1;
        #1;
        chk("fl_next_data", 32'(bus_a.stream_out_data), 32'h5C);
        tick();
        chk("fl_next_xfer", 32'(bus_a.xfer_count), 32'd20);
        bus_a.stream_out_ready = 1'b0;

        // Narrow counter wraps after four pops
        bus_b.stream_in_valid  = 1'b1;
        bus_b.stream_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus_b.stream_in_data = 8'(8'h30 + k);
            tick();
        end
        bus_b.stream_in_valid = 1'b0;
        tick();
        chk("wrap_xfer", 32'(bus_b.xfer_count), 32'd1);
        chk("wrap_level", 32'(bus_b.level), 32'd0);

        // Asynchronous reset in the middle of a burst
        bus_b.stream_out_ready = 1'b0;
        bus_b.stream_in_valid  = 1'b1;
        bus_b.stream_in_data   = 8'h77;
        tick();
        tick();
        chk("mid_level_pre", 32'(bus_b.level), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_level", 32'(bus_b.level), 32'd0);
        chk("async_valid", 32'(bus_b.stream_out_valid), 32'd0);
        chk("async_ready", 32'(bus_b.stream_in_ready), 32'd0);
        chk("async_xfer", 32'(bus_b.xfer_count), 32'd0);
        chk("async_data", 32'(bus_b.stream_out_data), 32'd0);
        chk("async_af", 32'(bus_b.almost_full), 32'd0);
        bus_b.stream_in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
